pe_dbuf: RTL and testbench
==========================

PE_DBUF -- requirements
Module: pe_dbuf

Interface
REQ-001 Parameter DATA_W, default 8, width of data and weight operands.
REQ-002 Parameter ACC_W, default 20, width of partial-sum path; ACC_W >= 2*DATA_W SHALL be enforced at elaboration.
REQ-003 Parameter SIGNED, default 1; 1 = two's-complement operands and sums, 0 = unsigned.
REQ-004 Parameter SAT, default 1; 1 = saturating accumulate, 0 = modulo-2^ACC_W wrap.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 data_i  in  DATA_W  activation from left neighbour.
REQ-008 data_valid_i  in  1  data_i and sum_i qualifier.
REQ-009 sum_i  in  ACC_W  partial sum from upper neighbour.
REQ-010 weight_i  in  DATA_W  weight shift-chain input from above.
REQ-011 weight_load_i  in  1  weight_i valid for shadow load.
REQ-012 weight_swap_i  in  1  copy shadow weight into active weight.
REQ-013 clr_ovf_i  in  1  clear sticky overflow flag.
REQ-014 data_o / data_valid_o  out  DATA_W / 1  registered activation to right neighbour.
REQ-015 sum_o  out  ACC_W  registered partial sum to lower neighbour.
REQ-016 weight_o / weight_load_o / weight_swap_o  out  DATA_W / 1 / 1  registered weight chain to lower neighbour.
REQ-017 ovf_o  out  1  sticky overflow/saturation indicator.

Function
REQ-018 Shadow weight register SHALL load weight_i on each cycle weight_load_i=1, otherwise hold.
REQ-019 weight_o, weight_load_o, weight_swap_o SHALL equal weight_i, weight_load_i, weight_swap_i delayed by exactly one cycle, unconditionally.
REQ-020 Active weight SHALL take the shadow value on each cycle weight_swap_i=1; load and swap in the same cycle: active takes the pre-load shadow, shadow takes weight_i.
REQ-021 When data_valid_i=1, sum_o SHALL become acc(active*data_i + sum_i) one cycle later; the product uses the active weight before any same-cycle swap.
REQ-022 Product SHALL be computed at full 2*DATA_W width and sign- (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W+1 bits before the add.
REQ-023 SAT=1: sums above the ACC_W max clamp to max, below the min clamp to min (signed: 2^(ACC_W-1)-1 / -2^(ACC_W-1); unsigned: 2^ACC_W-1 / 0); SAT=0: low ACC_W bits kept.
REQ-024 ovf_o SHALL set on the cycle after any valid accumulate whose exact result is out of range (either SAT mode) and hold until clr_ovf_i; set and clear in the same cycle: set wins.
REQ-025 data_o SHALL register data_i and data_valid_o SHALL register data_valid_i each cycle; latency 1.
REQ-026 When data_valid_i=0, sum_o and data_o SHALL hold their previous values and data_valid_o SHALL be 0.
REQ-027 No back-pressure; a valid input SHALL be accepted every cycle, giving sustained throughput of one MAC per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately clear data_o, data_valid_o, sum_o, weight_o, weight_load_o, weight_swap_o, ovf_o, shadow and active weights to 0, regardless of clk.
REQ-029 Reset asserted mid-stream SHALL discard in-flight data; the first valid input after deassertion computes with active weight 0.
REQ-030 Outputs SHALL stay at reset values until the first rising edge after rst_n deasserts.

Verification
REQ-031 Defaults; load 3, swap, then data_i=5, sum_i=10 valid -> sum_o=25, data_o=5, data_valid_o=1 one cycle later.
REQ-032 SIGNED=1, active weight -128, data_i=-128, sum_i=0 -> sum_o=16384, ovf_o=0; repeat with sum_i=2^19-1 -> sum_o=524287 (SAT=1), ovf_o=1.
REQ-033 SAT=0, same overflow -> sum_o = low 20 bits of exact result, ovf_o=1; clr_ovf_i pulse -> ovf_o=0 next cycle.
REQ-034 Active=2, shadow=7, swap with valid data_i=4, sum_i=0 in the same cycle -> sum_o=8; next valid data_i=4 -> sum_o=28.
REQ-035 Load and swap in the same cycle with weight_i=9, shadow=6 -> active=6, shadow=9; weight_o=9 and weight_swap_o=1 one cycle later.
REQ-036 Assert rst_n low between clock edges during valid streaming -> all outputs 0 before the next edge; after release, data_i=5 valid -> sum_o=sum_i.

Source files
------------

// File: rtl/pe_dbuf_if.sv
// Link bundle between a pe_dbuf cell and its neighbours: activation/sum inputs,
// weight shift chain, overflow control, and the registered outputs.
interface pe_dbuf_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic [DATA_W-1:0] data_i;
  logic              data_valid_i;
  logic [ACC_W-1:0]  sum_i;
  logic [DATA_W-1:0] weight_i;
  logic              weight_load_i;
  logic              weight_swap_i;
  logic              clr_ovf_i;

  logic [DATA_W-1:0] data_o;
  logic              data_valid_o;
  logic [ACC_W-1:0]  sum_o;
  logic [DATA_W-1:0] weight_o;
  logic              weight_load_o;
  logic              weight_swap_o;
  logic              ovf_o;

  modport slave (
    input  data_i, data_valid_i, sum_i, weight_i, weight_load_i, weight_swap_i, clr_ovf_i,
    output data_o, data_valid_o, sum_o, weight_o, weight_load_o, weight_swap_o, ovf_o
  );

  modport master (
    output data_i, data_valid_i, sum_i, weight_i, weight_load_i, weight_swap_i, clr_ovf_i,
    input  data_o, data_valid_o, sum_o, weight_o, weight_load_o, weight_swap_o, ovf_o
  );
endinterface

// File: rtl/pe_dbuf.sv
// Systolic-array processing element: one MAC per cycle with a double-buffered
// (shadow/active) weight, optional saturation and a sticky overflow flag.
module pe_dbuf #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input logic        clk,
  input logic        rst_n,
  pe_dbuf_if.slave   bus
);

  localparam int PW = 2 * DATA_W;
  localparam int XW = ACC_W + 1;

  generate
    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("pe_dbuf: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  logic [DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0] active_w;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic [ACC_W-1:0]  sum_q;
  logic [DATA_W-1:0] weight_q;
  logic              weight_load_q;
  logic              weight_swap_q;
  logic              ovf_q;

  logic [PW-1:0]     prod;
  logic [XW-1:0]     prod_x;
  logic [XW-1:0]     sum_x;
  logic [XW-1:0]     exact;
  logic [ACC_W-1:0]  sat_val;
  logic              ovf_raw;
  logic [ACC_W-1:0]  mac_res;

  // One extra bit of headroom is enough to hold any product plus any partial sum exactly.
  always_comb begin
    prod    = '0;
    prod_x  = '0;
    sum_x   = '0;
    exact   = '0;
    sat_val = '0;
    ovf_raw = 1'b0;
    mac_res = '0;
    if (SIGNED != 0) begin
      prod   = $signed({{DATA_W{active_w[DATA_W-1]}}, active_w})
             * $signed({{DATA_W{bus.data_i[DATA_W-1]}}, bus.data_i});
      prod_x = {{(XW-PW){prod[PW-1]}}, prod};
      sum_x  = {bus.sum_i[ACC_W-1], bus.sum_i};
    end else begin
      prod   = {{DATA_W{1'b0}}, active_w} * {{DATA_W{1'b0}}, bus.data_i};
      prod_x = {{(XW-PW){1'b0}}, prod};
      sum_x  = {1'b0, bus.sum_i};
    end
    exact = prod_x + sum_x;
    if (SIGNED != 0) begin
      ovf_raw = exact[XW-1] ^ exact[XW-2];
      sat_val = exact[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_raw = exact[XW-1];
      sat_val = '1;
    end
    mac_res = ((SAT != 0) && ovf_raw) ? sat_val : exact[ACC_W-1:0];
  end

  // Swap reads the shadow before this cycle's load lands, so both can share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w      <= '0;
      active_w      <= '0;
      weight_q      <= '0;
      weight_load_q <= 1'b0;
      weight_swap_q <= 1'b0;
    end else begin
      weight_q      <= bus.weight_i;
      weight_load_q <= bus.weight_load_i;
      weight_swap_q <= bus.weight_swap_i;
      if (bus.weight_load_i) shadow_w <= bus.weight_i;
      if (bus.weight_swap_i) active_w <= shadow_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sum_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      data_valid_q <= bus.data_valid_i;
      if (bus.data_valid_i) begin
        data_q <= bus.data_i;
        sum_q  <= mac_res;
      end
      if (bus.data_valid_i && ovf_raw) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.data_o        = data_q;
  assign bus.data_valid_o  = data_valid_q;
  assign bus.sum_o         = sum_q;
  assign bus.weight_o      = weight_q;
  assign bus.weight_load_o = weight_load_q;
  assign bus.weight_swap_o = weight_swap_q;
  assign bus.ovf_o         = ovf_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// Scoreboard bench for pe_dbuf: signed/saturating, signed/wrapping and
// unsigned/saturating instances share one stimulus stream and one model.
module tb_pe_dbuf;

  localparam int DW = 8;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pe_dbuf_if #(.DATA_W(DW), .ACC_W(AW)) bus_s ();
  pe_dbuf_if #(.DATA_W(DW), .ACC_W(AW)) bus_w ();
  pe_dbuf_if #(.DATA_W(DW), .ACC_W(AW)) bus_u ();

  pe_dbuf #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  pe_dbuf #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1), .SAT(0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  pe_dbuf #(.DATA_W(DW), .ACC_W(AW), .SIGNED(0), .SAT(1)) dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));

  typedef struct {
    logic [AW-1:0] sum_s, sum_w, sum_u;
    logic          ovf_s, ovf_w, ovf_u;
    logic [DW-1:0] data;
    logic          valid;
    logic [DW-1:0] wgt;
    logic          ld, sw;
  } exp_t;

  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  logic [DW-1:0] m_active, m_shadow, m_data;
  logic [AW-1:0] m_sum_s, m_sum_w, m_sum_u;
  logic          m_ovf_s, m_ovf_w, m_ovf_u;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    else
      passed++;
  endtask

  // Exact integer reference; clamps or wraps the 64-bit result into AW bits.
  task automatic modelMac(input bit sgn, input bit sat, input logic [DW-1:0] a, input logic [DW-1:0] d,
                          input logic [AW-1:0] s, output logic [AW-1:0] res, output logic ovf);
    longint av, dv, sv, ex, lo, hi;
    logic [63:0] bits;
    if (sgn) begin
      av = longint'($signed(a));
      dv = longint'($signed(d));
      sv = longint'($signed(s));
      lo = -(longint'(1) <<< (AW-1));
      hi = (longint'(1) <<< (AW-1)) - 1;
    end else begin
      av = longint'(a);
      dv = longint'(d);
      sv = longint'(s);
      lo = 0;
      hi = (longint'(1) <<< AW) - 1;
    end
    ex   = av * dv + sv;
    ovf  = (ex > hi) || (ex < lo);
    if (sat && ex > hi)      ex = hi;
    else if (sat && ex < lo) ex = lo;
    bits = ex;
    res  = bits[AW-1:0];
  endtask

  task automatic modelReset();
    m_active = '0; m_shadow = '0; m_data = '0;
    m_sum_s = '0; m_sum_w = '0; m_sum_u = '0;
    m_ovf_s = 1'b0; m_ovf_w = 1'b0; m_ovf_u = 1'b0;
    sb.delete();
  endtask

  task automatic driveAll(input logic [DW-1:0] d, input logic v, input logic [AW-1:0] s,
                          input logic [DW-1:0] w, input logic ld, input logic sw, input logic clr);
    bus_s.data_i = d; bus_s.data_valid_i = v; bus_s.sum_i = s; bus_s.weight_i = w;
    bus_s.weight_load_i = ld; bus_s.weight_swap_i = sw; bus_s.clr_ovf_i = clr;
    bus_w.data_i = d; bus_w.data_valid_i = v; bus_w.sum_i = s; bus_w.weight_i = w;
    bus_w.weight_load_i = ld; bus_w.weight_swap_i = sw; bus_w.clr_ovf_i = clr;
    bus_u.data_i = d; bus_u.data_valid_i = v; bus_u.sum_i = s; bus_u.weight_i = w;
    bus_u.weight_load_i = ld; bus_u.weight_swap_i = sw; bus_u.clr_ovf_i = clr;
  endtask

  task automatic checkCycle();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput("sum_s",   bus_s.sum_o,         e.sum_s);
    checkOutput("sum_w",   bus_w.sum_o,         e.sum_w);
    checkOutput("sum_u",   bus_u.sum_o,         e.sum_u);
    checkOutput("ovf_s",   bus_s.ovf_o,         e.ovf_s);
    checkOutput("ovf_w",   bus_w.ovf_o,         e.ovf_w);
    checkOutput("ovf_u",   bus_u.ovf_o,         e.ovf_u);
    checkOutput("data_o",  bus_s.data_o,        e.data);
    checkOutput("dval_o",  bus_s.data_valid_o,  e.valid);
    checkOutput("wgt_o",   bus_s.weight_o,      e.wgt);
    checkOutput("wld_o",   bus_s.weight_load_o, e.ld);
    checkOutput("wsw_o",   bus_s.weight_swap_o, e.sw);
    checkOutput("data_ow", bus_w.data_o,        e.data);
    checkOutput("data_ou", bus_u.data_o,        e.data);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic v, input logic [AW-1:0] s,
                               input logic [DW-1:0] w, input logic ld, input logic sw, input logic clr);
    exp_t e;
    logic [AW-1:0] r;
    logic o;
    @(negedge clk);
    driveAll(d, v, s, w, ld, sw, clr);
    if (v) begin
      m_data = d;
      modelMac(1'b1, 1'b1, m_active, d, s, r, o);
      m_sum_s = r;
      if (o) m_ovf_s = 1'b1; else if (clr) m_ovf_s = 1'b0;
      modelMac(1'b1, 1'b0, m_active, d, s, r, o);
      m_sum_w = r;
      if (o) m_ovf_w = 1'b1; else if (clr) m_ovf_w = 1'b0;
      modelMac(1'b0, 1'b1, m_active, d, s, r, o);
      m_sum_u = r;
      if (o) m_ovf_u = 1'b1; else if (clr) m_ovf_u = 1'b0;
    end else if (clr) begin
      m_ovf_s = 1'b0; m_ovf_w = 1'b0; m_ovf_u = 1'b0;
    end
    e.sum_s = m_sum_s; e.sum_w = m_sum_w; e.sum_u = m_sum_u;
    e.ovf_s = m_ovf_s; e.ovf_w = m_ovf_w; e.ovf_u = m_ovf_u;
    e.data  = m_data;  e.valid = v;
    e.wgt   = w;       e.ld = ld; e.sw = sw;
    sb.push_back(e);
    if (sw) m_active = m_shadow;
    if (ld) m_shadow = w;
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_sum_s"}, bus_s.sum_o, 32'd0);
    checkOutput({tag, "_sum_w"}, bus_w.sum_o, 32'd0);
    checkOutput({tag, "_sum_u"}, bus_u.sum_o, 32'd0);
    checkOutput({tag, "_ovf_s"}, bus_s.ovf_o, 32'd0);
    checkOutput({tag, "_ovf_w"}, bus_w.ovf_o, 32'd0);
    checkOutput({tag, "_data"},  bus_s.data_o, 32'd0);
    checkOutput({tag, "_dval"},  bus_s.data_valid_o, 32'd0);
    checkOutput({tag, "_wgt"},   bus_s.weight_o, 32'd0);
    checkOutput({tag, "_wld"},   bus_s.weight_load_o, 32'd0);
    checkOutput({tag, "_wsw"},   bus_s.weight_swap_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    driveAll('0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    modelReset();
    #12;
    checkReset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkReset("rel");

    $display("[TB] basic MAC: weight 3, data 5, sum 10");
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd5, 1'b1, 20'd10, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("basic_25", bus_s.sum_o, 32'd25);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] signed extremes and saturation");
    applyStimulus(8'd0, 1'b0, 20'd0, 8'h80, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h80, 1'b1, 20'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("neg_sq", bus_s.sum_o, 32'd16384);
    applyStimulus(8'h80, 1'b1, 20'h7FFFF, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_max", bus_s.sum_o, 32'd524287);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h80, 1'b1, 20'h7FFFF, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h7F, 1'b1, 20'h80000, 8'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'hFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 20'hFFFFF, 8'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] swap concurrent with valid data");
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd4, 1'b1, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("swap_8", bus_s.sum_o, 32'd8);
    applyStimulus(8'd4, 1'b1, 20'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("swap_28", bus_s.sum_o, 32'd28);

    $display("[TB] load and swap in the same cycle");
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd9, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'd1, 1'b1, 20'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ldsw_act6", bus_s.sum_o, 32'd6);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'd1, 1'b1, 20'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("ldsw_sh9", bus_s.sum_o, 32'd9);

    $display("[TB] random stream");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom()), ($urandom_range(0, 3) != 0), 20'($urandom()), 8'($urandom()),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset during streaming");
    applyStimulus(8'd3, 1'b1, 20'd100, 8'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    driveAll(8'd7, 1'b1, 20'd55, 8'd4, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("mid");
    driveAll('0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    checkReset("hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkReset("rel2");
    applyStimulus(8'd5, 1'b1, 20'h00123, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst", bus_s.sum_o, 32'h123);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
